intr_req_ack_rx_mc: RTL
=======================

Name: intr_req_ack_rx_mc

Overview:
Multi-channel receive-side request/acknowledge handshake engine for the camera controller. It sits in the consuming clock domain.
- Synchronizes NUM_CH asynchronous request lines.
- Runs a per-channel handshake FSM in either 4-phase (level) or 2-phase (toggle) protocol.
- Presents each request as a valid/ready event to local logic.
- Returns a registered acknowledge, which the requesting side synchronizes.
- Adds timeout and overrun detection, which the plain two-way synchronizer pair lacks.

Parameters:
- NUM_CH, 4: number of independent request/ack channels (1..32).
- NUM_FLOPS, 2: synchronizer stages per request line (>=2).
- RST_VAL, 0: reset value of the synchronizer flops and of the edge-detect history register.
- PROTOCOL, 0: 0 = 4-phase level handshake; 1 = 2-phase toggle handshake.
- TIMEOUT_CYC, 1024: 4-phase only; clk cycles allowed for req to drop after ack rises. 0 disables the timeout.

Ports:
- clk  input  1  consuming-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- req_async  input  NUM_CH  asynchronous request lines from the requesting domain.
- ack_out  output  NUM_CH  registered acknowledge lines to the requesting domain.
- evt_valid  output  NUM_CH  per-channel event pending to local logic.
- evt_ready  input  NUM_CH  per-channel event accept from local logic.
- busy  output  NUM_CH  channel FSM not in IDLE.
- err  output  NUM_CH  sticky error: timeout (PROTOCOL=0) or overrun (PROTOCOL=1).
- err_clr  input  NUM_CH  per-channel clear of the err bit.

Behaviour:
- Reset (async assert, sync release): sync flops and history reg = RST_VAL; FSM = IDLE; ack_out, evt_valid, busy, err = 0; timeout counter = 0.
- Sync: req_async[i] passes through a NUM_FLOPS chain, producing req_s[i]. A history reg req_d[i] <= req_s[i] every cycle.
- Edge detect:
  - 4-phase: rise = req_s & ~req_d.
  - 2-phase: tog = req_s ^ req_d.
- Latency: evt_valid asserts NUM_FLOPS+1 clk edges after the first edge that samples req_async high (or toggled).
- Handshake rule: event accepted when evt_valid & evt_ready in the same cycle. evt_valid is held until accepted; it never drops unaccepted (except on reset).
- 4-phase FSM (states IDLE, PEND, ACK):
  - IDLE -> PEND on rise. evt_valid = 1 in PEND.
  - PEND -> ACK on accept. ack_out goes 1 on the same edge that clears evt_valid. Timeout counter is cleared.
  - ACK -> IDLE when req_s = 0; ack_out goes 0 on that edge.
  - In ACK the counter increments each cycle, saturating at TIMEOUT_CYC. On reaching TIMEOUT_CYC (TIMEOUT_CYC != 0), err sets. The FSM stays in ACK with ack_out held at 1 until req drops.
  - Request withdrawn during PEND (protocol violation): the event is still delivered. ACK then sees req_s = 0 and returns to IDLE one cycle later with a single-cycle ack_out pulse.
  - A rise while not IDLE is ignored.
- 2-phase FSM (states IDLE, PEND; ack_out is a level mirror):
  - IDLE -> PEND on tog.
  - PEND -> IDLE on accept. ack_out <= req_s on the accept edge, so ack_out equals the last accepted request level.
  - tog while in PEND sets err (overrun). Toggles are merged: only one event is delivered, and ack_out still follows the current req_s at accept.
- busy = (state != IDLE), registered alongside the state.
- err: set has priority over a simultaneous err_clr. err_clr with no set clears the bit on the next edge.
- Counter width is $clog2(TIMEOUT_CYC+1). The counter is not instantiated when PROTOCOL=1 or TIMEOUT_CYC=0.
- Channels are fully independent; simultaneous events on all channels are legal.
- Reset mid-handshake aborts all channels to IDLE with ack_out = 0. A request still high afterwards is re-detected only on a new rise/toggle relative to RST_VAL.

Test Plan:
- NUM_CH=4, PROTOCOL=0, NUM_FLOPS=2: raise req_async[1], hold evt_ready=1 -> evt_valid[1] high 3 edges after capture, ack_out[1] high next edge; drop req -> ack_out[1] low 3 edges later; busy[1] follows; other channels stay 0.
- PROTOCOL=0, evt_ready=0 for 20 cycles on ch0 -> evt_valid[0] held 20 cycles, ack_out[0] stays 0; assert ready -> ack_out[0]=1 on the next edge.
- PROTOCOL=0, TIMEOUT_CYC=8, req held high after ack -> err[0]=1 after 8 cycles in ACK while ack_out stays 1; err_clr and timeout set in the same cycle -> err stays 1; err_clr later alone -> err=0.
- PROTOCOL=1: three toggles on ch2 spaced 10 cycles, ready=1 -> three evt_valid pulses, ack_out[2] toggles 0->1->0->1, err=0; two toggles while ready=0 -> one event, err[2]=1, ack_out[2] = final req level.
- All 4 channels raise in the same cycle with staggered ready -> each channel's event and ack are independent and correct.
- rst_n asserted during ACK with req high -> all outputs 0 immediately; after release with req still high and RST_VAL=0 -> one new event is detected.

Source files
------------

// File: rtl/intr_req_ack_rx_mc.sv
// Receive-side request/acknowledge engine: synchronizes NUM_CH request lines and runs an
// independent 4-phase or 2-phase handshake per channel, with timeout/overrun error flags.
module intr_req_ack_rx_mc #(
    parameter int   NUM_CH      = 4,
    parameter int   NUM_FLOPS   = 2,
    parameter logic RST_VAL     = 1'b0,
    parameter int   PROTOCOL    = 0,
    parameter int   TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_async,
    output logic [NUM_CH-1:0] ack_out,
    output logic [NUM_CH-1:0] evt_valid,
    input  logic [NUM_CH-1:0] evt_ready,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] err,
    input  logic [NUM_CH-1:0] err_clr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam bit         USE_TMO = (PROTOCOL == 0) && (TIMEOUT_CYC != 0);

    logic [NUM_CH-1:0] sync_q [NUM_FLOPS];
    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] req_d;
    logic [NUM_CH-1:0] edge_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FLOPS; k++) sync_q[k] <= {NUM_CH{RST_VAL}};
            req_d <= {NUM_CH{RST_VAL}};
        end else begin
            sync_q[0] <= req_async;
            for (int k = 1; k < NUM_FLOPS; k++) sync_q[k] <= sync_q[k-1];
            req_d <= req_s;
        end
    end

    assign req_s    = sync_q[NUM_FLOPS-1];
    // Level protocol reacts to rising edges only; toggle protocol to any change.
    assign edge_hit = (PROTOCOL == 1) ? (req_s ^ req_d) : (req_s & ~req_d);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] state;
        logic       ack_q;
        logic       err_q;
        logic       tmo_hit;
        logic       ovr_hit;
        logic       err_set;

        if (USE_TMO) begin : g_tmo
            localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (state == ST_PEND && evt_ready[i]) begin
                    cnt <= '0;
                end else if (state == ST_ACK && req_s[i] && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Fires once, on the edge the saturating count reaches its limit.
            assign tmo_hit = (state == ST_ACK) && req_s[i] && (cnt == CNT_LAST);
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end

        assign ovr_hit = (PROTOCOL == 1) && (state == ST_PEND) && edge_hit[i];
        assign err_set = tmo_hit | ovr_hit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_IDLE;
                ack_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (edge_hit[i]) state <= ST_PEND;
                    ST_PEND: begin
                        if (evt_ready[i]) begin
                            if (PROTOCOL == 1) begin
                                state <= ST_IDLE;
                                ack_q <= req_s[i];
                            end else begin
                                state <= ST_ACK;
                                ack_q <= 1'b1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (!req_s[i]) begin
                            state <= ST_IDLE;
                            ack_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ack_q <= 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr[i]) begin
                err_q <= 1'b0;
            end
        end

        assign ack_out[i]   = ack_q;
        assign evt_valid[i] = (state == ST_PEND);
        assign busy[i]      = (state != ST_IDLE);
        assign err[i]       = err_q;
    end

endmodule
